led: RTL and testbench

//  Retriggerable pulse stretcher for driving a front-panel LED from short strobes.
//  A trigger lasting one or more clock cycles produces an output pulse of COUNT

---
 rtl/led.sv | 51 +++++
 tb/tb_led.sv | 129 ++++++++++++
 2 files changed

// File: rtl/led.sv
// led: retriggerable pulse stretcher for a front-panel LED.
//
// A trigger of one or more cycles produces an out pulse COUNT clk cycles long.
// With RETRIG=1 a trigger during an active pulse restarts the count. With
// RETRIG=0 such a trigger is ignored.
//
// Ports
//   clk   system clock; everything updates on its rising edge
//   rst   synchronous reset, active-high, has priority over trig
//   trig  trigger strobe, level-sampled on each edge
//   out   LED drive, registered, active-high; out == (cnt != 0)
module led #(
  parameter int COUNT  = 4000000,
  parameter bit RETRIG = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic out
);

  // Widen before adding 1 so that COUNT = 2**31-1 does not overflow.
  localparam int CW_RAW = $clog2(longint'(COUNT) + 64'sd1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  if (COUNT < 1) begin : g_bad_count
    $fatal(1, "led: COUNT must be at least 1");
  end

  logic [CW-1:0] cnt;

  // The counter is only ever loaded with COUNT or decremented while above 1.
  // It therefore settles at 0 and cannot wrap. out is registered next to cnt,
  // so trig has no combinational path to the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (trig && (RETRIG || cnt == '0)) begin
      cnt <= CW'(COUNT);
      out <= 1'b1;
    end else if (cnt > CW'(1)) begin
      cnt <= cnt - CW'(1);
      out <= 1'b1;
    end else begin
      cnt <= '0;
      out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led.sv
module tb_led;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0, trig0 = 1'b0, trig1 = 1'b0;
  logic out, out0, out1;

  int n_chk  = 0;
  int n_fail = 0;

  always #12.5 clk = ~clk;  // 25 ns period

  // Main instance: COUNT=100, RETRIG=1
  led #(.COUNT(100), .RETRIG(1'b1)) dut  (.clk(clk), .rst(rst), .trig(trig),  .out(out));
  // Non-retriggerable instance
  led #(.COUNT(100), .RETRIG(1'b0)) dut0 (.clk(clk), .rst(rst), .trig(trig0), .out(out0));
  // Minimum pulse length
  led #(.COUNT(1),   .RETRIG(1'b1)) dut1 (.clk(clk), .rst(rst), .trig(trig1), .out(out1));

  typedef struct {
    string name;
    logic  rst;
    logic  trig;
    int    n;      // number of edges this row is applied for
    logic  exp;    // expected out after each of those edges
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: out=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic r, input logic t, input logic t0, input logic t1);
    @(negedge clk);
    rst = r; trig = t; trig0 = t0; trig1 = t1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Scenario 1: reset with trig low
    tbl.push_back('{"rst_hold",     1'b1, 1'b0, 4,   1'b0});
    tbl.push_back('{"rst_release",  1'b0, 1'b0, 3,   1'b0});
    // Scenario 2: single one-cycle strobe gives 100 high cycles
    tbl.push_back('{"s2_trig",      1'b0, 1'b1, 1,   1'b1});
    tbl.push_back('{"s2_high",      1'b0, 1'b0, 99,  1'b1});
    tbl.push_back('{"s2_fall",      1'b0, 1'b0, 5,   1'b0});
    // Scenario 3: a retrigger 40 cycles in extends the pulse with no gap
    tbl.push_back('{"s3_trig1",     1'b0, 1'b1, 1,   1'b1});
    tbl.push_back('{"s3_high1",     1'b0, 1'b0, 39,  1'b1});
    tbl.push_back('{"s3_trig2",     1'b0, 1'b1, 1,   1'b1});
    tbl.push_back('{"s3_high2",     1'b0, 1'b0, 99,  1'b1});
    tbl.push_back('{"s3_fall",      1'b0, 1'b0, 1,   1'b0});
    // Scenario 4: 10 us idle, then a fresh pulse
    tbl.push_back('{"s4_idle",      1'b0, 1'b0, 400, 1'b0});
    tbl.push_back('{"s4_trig",      1'b0, 1'b1, 1,   1'b1});
    tbl.push_back('{"s4_high",      1'b0, 1'b0, 99,  1'b1});
    tbl.push_back('{"s4_fall",      1'b0, 1'b0, 5,   1'b0});
    // Scenario 5a: trig held for 5 cycles gives 104 high cycles
    tbl.push_back('{"s5_hold",      1'b0, 1'b1, 5,   1'b1});
    tbl.push_back('{"s5_high",      1'b0, 1'b0, 99,  1'b1});
    tbl.push_back('{"s5_fall",      1'b0, 1'b0, 1,   1'b0});
    // Scenario 5b: reset at cycle 50 wins over a coincident trig
    tbl.push_back('{"s5r_trig",     1'b0, 1'b1, 1,   1'b1});
    tbl.push_back('{"s5r_high",     1'b0, 1'b0, 48,  1'b1});
    tbl.push_back('{"s5r_rst_trig", 1'b1, 1'b1, 1,   1'b0});
    tbl.push_back('{"s5r_after",    1'b0, 1'b0, 3,   1'b0});

    // Apply the table
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        step(tbl[i].rst, tbl[i].trig, 1'b0, 1'b0);
        check(tbl[i].name, out, tbl[i].exp);
      end
      if (tbl[i].name == "rst_release") begin
        n_chk++;
        if (dut.cnt !== '0) begin
          n_fail++;
          $display("FAIL rst_cnt: cnt=%0d expected 0", dut.cnt);
        end
      end
    end

    // Scenario 6a, RETRIG=0. A trig at cycle 40 is ignored, so the pulse still
    // ends after 100 cycles. A trig on the 1->0 edge is also ignored. The
    // following trig starts a new pulse.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("r0_trig", out0, 1'b1);
    for (int c = 1; c < 100; c++) begin
      step(1'b0, 1'b0, (c == 40), 1'b0);
      check("r0_high", out0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);      // cnt is 1 here, so this trig is ignored
    check("r0_edge_trig_ignored", out0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);      // cnt is 0, so this one loads
    check("r0_retrig_after_idle", out0, 1'b1);
    for (int c = 1; c < 100; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("r0_high2", out0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("r0_fall2", out0, 1'b0);

    // Scenario 6b, COUNT=1. A single trig gives a one-cycle pulse, and
    // back-to-back trigs keep out high.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("c1_single", out1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("c1_single_fall", out1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("c1_idle", out1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("c1_b2b", out1, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("c1_b2b_fall", out1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
